// File: rtl/router_out_arb.sv
// ---------------------------------------------------------------------------
// router_out_arb
//
// Output-port arbiter for a wormhole router with two virtual channels (VCs)
// and five input ports.  Each VC is allocated to one input port at a time by
// a head flit.  The owning port then streams its flits until a tail flit
// releases the VC.  A credit counter per VC tracks free downstream buffer
// slots.  At most one flit crosses the link per cycle; when both VCs could
// send, the link alternates between them.
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   RST_       synchronous, active-high reset
//   REQ_VALID  [4:0] per input port: a flit is present for this output
//   REQ_VCH    [4:0] per input port: requested output VC (0/1)
//   REQ_HEAD   [4:0] per input port: flit is a head flit
//   REQ_TAIL   [4:0] per input port: flit is a tail flit
//   IACK       [1:0] per VC: one credit returned by downstream this cycle
//   GNT        [4:0] one-hot or zero: port whose flit is transferred now
//   OVALID     a flit is transferred this cycle (OR of GNT)
//   OVCH       VC of the transferred flit, 0 when OVALID is low
//   VC_BUSY    [1:0] per VC: VC is owned by an input port
//   VC_OWNER   [5:0] 3 bits per VC ([2:0] VC0, [5:3] VC1): owner, 0 if free
//   CREDIT     [5:0] 3 bits per VC: current credit count
//   ERR        sticky credit-overflow flag
// ---------------------------------------------------------------------------
module router_out_arb #(
    parameter int CREDITS = 4
) (
    input  logic       clk,
    input  logic       RST_,
    input  logic [4:0] REQ_VALID,
    input  logic [4:0] REQ_VCH,
    input  logic [4:0] REQ_HEAD,
    input  logic [4:0] REQ_TAIL,
    input  logic [1:0] IACK,
    output logic [4:0] GNT,
    output logic       OVALID,
    output logic       OVCH,
    output logic [1:0] VC_BUSY,
    output logic [5:0] VC_OWNER,
    output logic [5:0] CREDIT,
    output logic       ERR
);

    localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);
    localparam logic [2:0] LAST_PORT  = 3'd4;

    typedef enum logic {
        VC_FREE  = 1'b0,
        VC_OWNED = 1'b1
    } vc_state_t;

    // Round-robin search over the five ports, starting one past the last
    // winner and wrapping 4 -> 0.  Result is {found, port_index}.
    function automatic logic [3:0] rr_pick(input logic [4:0] cand,
                                           input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        idx = last;
        for (int k = 0; k < 5; k++) begin
            idx = (idx >= LAST_PORT) ? 3'd0 : idx + 3'd1;
            if (!res[3] && cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Per-VC signals shared with the link arbiter.
    logic [1:0]      eligible;
    logic [1:0]      xfer;
    logic [1:0]      overflow;
    logic [1:0][4:0] owner_onehot;

    // Link arbiter state.
    logic serve_vc;
    logic last_vc_reg, last_vc_next;
    logic err_reg, err_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vc
            vc_state_t  state_reg, state_next;
            logic [2:0] owner_reg, owner_next;
            logic [2:0] last_alloc_reg, last_alloc_next;
            logic [2:0] credit_reg, credit_next;
            logic       overflow_next;
            logic [4:0] vch_match;
            logic [4:0] candidates;
            logic [3:0] pick;
            logic       owner_tail;

            // Ports whose current flit targets this VC.
            assign vch_match  = (gi == 0) ? ~REQ_VCH : REQ_VCH;
            assign candidates = REQ_VALID & REQ_HEAD & vch_match;
            assign pick       = rr_pick(candidates, last_alloc_reg);

            // One-hot owner, all zero while the VC is free, so it doubles as
            // the grant vector when this VC wins the link.
            assign owner_onehot[gi] = (state_reg == VC_OWNED)
                                    ? (5'b00001 << owner_reg) : 5'b00000;

            // The owner must be presenting a flit on this VC and there must
            // be downstream room.  Head flits from the owner are accepted as
            // ordinary flits here.
            assign eligible[gi] = (|(owner_onehot[gi] & REQ_VALID & vch_match))
                                  && (credit_reg != 3'd0);
            assign owner_tail   = |(owner_onehot[gi] & REQ_TAIL);

            always_comb begin
                state_next      = state_reg;
                owner_next      = owner_reg;
                last_alloc_next = last_alloc_reg;
                credit_next     = credit_reg;
                overflow_next   = 1'b0;

                case (state_reg)
                    VC_FREE: begin
                        // Allocation cycle: no flit moves on this VC yet.
                        if (pick[3]) begin
                            state_next      = VC_OWNED;
                            owner_next      = pick[2:0];
                            last_alloc_next = pick[2:0];
                        end
                    end
                    VC_OWNED: begin
                        if (xfer[gi] && owner_tail) begin
                            state_next = VC_FREE;
                            owner_next = 3'd0;
                        end
                    end
                    default: begin
                        state_next = VC_FREE;
                        owner_next = 3'd0;
                    end
                endcase

                // Transfer and returned credit in the same cycle cancel out.
                if (xfer[gi] && !IACK[gi]) begin
                    credit_next = credit_reg - 3'd1;
                end else if (!xfer[gi] && IACK[gi]) begin
                    if (credit_reg >= CREDIT_MAX) begin
                        overflow_next = 1'b1;
                    end else begin
                        credit_next = credit_reg + 3'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (RST_) begin
                    state_reg      <= VC_FREE;
                    owner_reg      <= 3'd0;
                    last_alloc_reg <= LAST_PORT;
                    credit_reg     <= CREDIT_MAX;
                end else begin
                    state_reg      <= state_next;
                    owner_reg      <= owner_next;
                    last_alloc_reg <= last_alloc_next;
                    credit_reg     <= credit_next;
                end
            end

            assign overflow[gi]        = overflow_next;
            assign VC_BUSY[gi]         = (state_reg == VC_OWNED);
            assign VC_OWNER[gi*3 +: 3] = owner_reg;
            assign CREDIT[gi*3 +: 3]   = credit_reg;
        end
    endgenerate

    // Link arbitration: with both VCs ready, serve the one not served last.
    always_comb begin
        serve_vc = 1'b0;
        if (&eligible) begin
            serve_vc = ~last_vc_reg;
        end else if (eligible[1]) begin
            serve_vc = 1'b1;
        end
    end

    // Reset blocks any transfer regardless of the request inputs.
    assign OVALID = !RST_ && (|eligible);
    assign GNT    = OVALID ? owner_onehot[serve_vc] : 5'b00000;
    assign OVCH   = OVALID & serve_vc;
    assign xfer   = {OVALID & serve_vc, OVALID & ~serve_vc};

    always_comb begin
        last_vc_next = last_vc_reg;
        err_next     = err_reg | (|overflow);
        if (OVALID) begin
            last_vc_next = serve_vc;
        end
    end

    always_ff @(posedge clk) begin
        if (RST_) begin
            last_vc_reg <= 1'b1;
            err_reg     <= 1'b0;
        end else begin
            last_vc_reg <= last_vc_next;
            err_reg     <= err_next;
        end
    end

    assign ERR = err_reg;

endmodule

// File: tb/tb_router_out_arb.sv
// ---------------------------------------------------------------------------
// tb_router_out_arb
//
// Self-checking bench for router_out_arb.  A behavioural model (ownership
// flags, owner indices, credit counts and round-robin pointers held as plain
// integers) predicts every output each cycle.  Directed sequences pin the
// model with literal expectations; a randomized phase then drives packet
// streams from all five ports with random bubbles, credit returns and resets.
// ---------------------------------------------------------------------------
module tb_router_out_arb;

    localparam int CREDITS = 4;

    logic       clk = 1'b0;
    logic       RST_;
    logic [4:0] REQ_VALID, REQ_VCH, REQ_HEAD, REQ_TAIL;
    logic [1:0] IACK;
    logic [4:0] GNT;
    logic       OVALID, OVCH;
    logic [1:0] VC_BUSY;
    logic [5:0] VC_OWNER, CREDIT;
    logic       ERR;

    always #5 clk = ~clk;

    router_out_arb #(.CREDITS(CREDITS)) dut (
        .clk      (clk),
        .RST_     (RST_),
        .REQ_VALID(REQ_VALID),
        .REQ_VCH  (REQ_VCH),
        .REQ_HEAD (REQ_HEAD),
        .REQ_TAIL (REQ_TAIL),
        .IACK     (IACK),
        .GNT      (GNT),
        .OVALID   (OVALID),
        .OVCH     (OVCH),
        .VC_BUSY  (VC_BUSY),
        .VC_OWNER (VC_OWNER),
        .CREDIT   (CREDIT),
        .ERR      (ERR)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Behavioural model state.
    bit m_owned[2];
    int m_owner[2];
    int m_credit[2];
    int m_last_alloc[2];
    int m_last_vc;
    bit m_err;

    // Model expectations for the current cycle.
    bit         e_x;
    int         e_sv;
    logic [4:0] e_gnt;

    // DUT outputs sampled at the falling edge.
    logic [4:0] s_gnt;
    logic       s_ovalid, s_ovch, s_err;
    logic [1:0] s_busy;
    logic [5:0] s_owner, s_credit;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cycle, act, exp);
        end
    endtask

    function automatic bit model_elig(input int v);
        int o;
        o = m_owner[v];
        return m_owned[v] && REQ_VALID[o] && (int'(REQ_VCH[o]) == v) && (m_credit[v] > 0);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_owned[v]      = 1'b0;
            m_owner[v]      = 0;
            m_credit[v]     = CREDITS;
            m_last_alloc[v] = 4;
        end
        m_last_vc = 1;
        m_err     = 1'b0;
    endtask

    task automatic model_update();
        if (RST_) begin
            model_reset();
        end else begin
            for (int v = 0; v < 2; v++) begin
                bit xv, iv, found;
                xv = e_x && (e_sv == v);
                iv = IACK[v];
                if (m_owned[v]) begin
                    if (xv && REQ_TAIL[m_owner[v]]) begin
                        m_owned[v] = 1'b0;
                        m_owner[v] = 0;
                    end
                end else begin
                    found = 1'b0;
                    for (int k = 1; k <= 5; k++) begin
                        int p;
                        p = (m_last_alloc[v] + k) % 5;
                        if (!found && REQ_VALID[p] && REQ_HEAD[p] && (int'(REQ_VCH[p]) == v)) begin
                            found           = 1'b1;
                            m_owned[v]      = 1'b1;
                            m_owner[v]      = p;
                            m_last_alloc[v] = p;
                        end
                    end
                end
                if (xv && !iv) m_credit[v] = m_credit[v] - 1;
                else if (!xv && iv) begin
                    if (m_credit[v] == CREDITS) m_err = 1'b1;
                    else m_credit[v] = m_credit[v] + 1;
                end
            end
            if (e_x) m_last_vc = e_sv;
        end
    endtask

    // One clock cycle: predict, compare at the falling edge, advance model.
    task automatic step();
        bit el0, el1;
        @(negedge clk);
        el0 = model_elig(0);
        el1 = model_elig(1);
        e_x = !RST_ && (el0 || el1);
        if (el0 && el1) e_sv = 1 - m_last_vc;
        else            e_sv = el1 ? 1 : 0;
        e_gnt = e_x ? 5'(1 << m_owner[e_sv]) : 5'd0;

        s_gnt = GNT; s_ovalid = OVALID; s_ovch = OVCH;
        s_busy = VC_BUSY; s_owner = VC_OWNER; s_credit = CREDIT; s_err = ERR;

        chk("gnt", s_gnt, e_gnt);
        chk("ovalid", s_ovalid, e_x);
        chk("ovch", s_ovch, e_x ? e_sv : 0);
        for (int v = 0; v < 2; v++) begin
            chk("vc_busy", s_busy[v], m_owned[v]);
            chk("vc_owner", s_owner[v*3 +: 3], m_owner[v]);
            chk("credit", s_credit[v*3 +: 3], m_credit[v]);
        end
        chk("err", s_err, m_err);
        if (e_x)
            $display("cyc=%0d xfer port=%0d vc=%0d credit0=%0d credit1=%0d",
                     cycle, m_owner[e_sv], e_sv, m_credit[0], m_credit[1]);

        @(posedge clk);
        model_update();
        cycle++;
        #1;
    endtask

    task automatic drive(input logic [4:0] va, input logic [4:0] vc,
                         input logic [4:0] hd, input logic [4:0] tl,
                         input logic [1:0] ia);
        REQ_VALID = va; REQ_VCH = vc; REQ_HEAD = hd; REQ_TAIL = tl; IACK = ia;
    endtask

    task automatic reset_dut();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 2'd0);
        RST_ = 1'b1;
        step();
        RST_ = 1'b0;
    endtask

    // Random-phase per-port packet state.
    bit p_active[5];
    int p_vc[5];
    int p_left[5];
    bit p_first[5];

    initial begin
        logic [4:0] exp_gnt35 [4];
        logic [4:0] exp_gnt34 [4];
        exp_gnt35 = '{5'b00010, 5'b10000, 5'b00010, 5'b10000};
        exp_gnt34 = '{5'b00001, 5'b00010, 5'b01000, 5'b00001};

        // Bring the DUT out of its unknown power-up state before comparing.
        drive(5'd0, 5'd0, 5'd0, 5'd0, 2'd0);
        RST_ = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Reset values.
        reset_dut();
        step();
        chk("rst_credit", s_credit, 6'b100100);
        chk("rst_busy", s_busy, 0);

        // Three-flit packet from port 2 on VC0.
        reset_dut();
        drive(5'b00100, 5'b00000, 5'b00100, 5'b00000, 2'b00);
        step();
        chk("p2_alloc_gnt", s_gnt, 0);
        step();
        chk("p2_gnt1", s_gnt, 5'b00100);
        chk("p2_owner", s_owner, 2);
        chk("p2_busy", s_busy, 2'b01);
        drive(5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b00);
        step();
        chk("p2_gnt2", s_gnt, 5'b00100);
        drive(5'b00100, 5'b00000, 5'b00000, 5'b00100, 2'b00);
        step();
        chk("p2_gnt3", s_gnt, 5'b00100);
        drive(5'd0, 5'd0, 5'd0, 5'd0, 2'd0);
        step();
        chk("p2_free", s_busy, 0);
        chk("p2_credit", s_credit, 6'b100001);

        // Credit exhaustion and recovery on VC0 (continues from credit 1).
        drive(5'b00100, 5'b00000, 5'b00100, 5'b00000, 2'b00);
        step();
        step();
        chk("cr_head_gnt", s_gnt, 5'b00100);
        drive(5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b00);
        step();
        chk("cr_zero_gnt", s_gnt, 0);
        chk("cr_zero_credit", s_credit[2:0], 0);
        drive(5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b01);
        step();
        chk("cr_iack_gnt", s_gnt, 0);
        drive(5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b00);
        step();
        chk("cr_after_iack_gnt", s_gnt, 5'b00100);
        drive(5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b01);
        step();
        drive(5'b00100, 5'b00000, 5'b00000, 5'b00100, 2'b01);
        step();
        chk("cr_simul_gnt", s_gnt, 5'b00100);
        drive(5'd0, 5'd0, 5'd0, 5'd0, 2'd0);
        step();
        chk("cr_simul_credit", s_credit[2:0], 1);
        chk("cr_free", s_busy, 0);

        // Credit overflow on idle VC1.
        reset_dut();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 2'b10);
        step();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 2'b00);
        step();
        chk("ovf_credit1", s_credit[5:3], 4);
        chk("ovf_err", s_err, 1);
        step();
        step();
        chk("ovf_err_sticky", s_err, 1);
        reset_dut();
        step();
        chk("ovf_err_cleared", s_err, 0);

        // Reset in the middle of a VC1 packet from port 3.
        reset_dut();
        drive(5'b01000, 5'b01000, 5'b01000, 5'b00000, 2'b00);
        step();
        step();
        chk("mid_gnt", s_gnt, 5'b01000);
        chk("mid_ovch", s_ovch, 1);
        drive(5'b01000, 5'b01000, 5'b00000, 5'b00000, 2'b00);
        RST_ = 1'b1;
        step();
        chk("mid_rst_gnt", s_gnt, 0);
        RST_ = 1'b0;
        drive(5'b01000, 5'b01000, 5'b01000, 5'b00000, 2'b00);
        step();
        chk("mid_post_busy", s_busy, 0);
        chk("mid_post_credit", s_credit, 6'b100100);
        chk("mid_post_gnt", s_gnt, 0);
        step();
        chk("mid_realloc_gnt", s_gnt, 5'b01000);
        chk("mid_realloc_owner", s_owner[5:3], 3);

        // Port 1 on VC0 and port 4 on VC1 streaming: link alternates.
        reset_dut();
        drive(5'b10010, 5'b10000, 5'b10010, 5'b00000, 2'b00);
        step();
        drive(5'b10010, 5'b10000, 5'b00000, 5'b00000, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alt_gnt", s_gnt, exp_gnt35[i]);
            chk("alt_ovch", s_ovch, i % 2);
        end

        // Ports 0,1,3 competing for VC0 with single-flit packets.
        reset_dut();
        drive(5'b01011, 5'b00000, 5'b01011, 5'b01011, 2'b00);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i % 2 == 1) chk("rr_gnt", s_gnt, exp_gnt34[i/2]);
            else            chk("rr_alloc_gnt", s_gnt, 0);
        end

        // Randomized packet traffic.
        reset_dut();
        for (int p = 0; p < 5; p++) p_active[p] = 1'b0;
        for (int n = 0; n < 800; n++) begin
            RST_ = ($urandom_range(0, 149) == 0);
            for (int p = 0; p < 5; p++) begin
                if (!p_active[p] && ($urandom_range(0, 3) == 0)) begin
                    p_active[p] = 1'b1;
                    p_vc[p]     = $urandom_range(0, 1);
                    p_left[p]   = $urandom_range(1, 4);
                    p_first[p]  = 1'b1;
                end
                REQ_VALID[p] = p_active[p] && ($urandom_range(0, 4) != 0);
                REQ_VCH[p]   = p_active[p] && (p_vc[p] == 1);
                REQ_HEAD[p]  = p_active[p] && p_first[p];
                REQ_TAIL[p]  = p_active[p] && (p_left[p] == 1);
            end
            for (int v = 0; v < 2; v++) begin
                if (m_credit[v] < CREDITS) IACK[v] = ($urandom_range(0, 1) == 1);
                else                       IACK[v] = ($urandom_range(0, 59) == 0);
            end
            step();
            if (RST_) begin
                for (int p = 0; p < 5; p++) p_active[p] = 1'b0;
            end else begin
                for (int p = 0; p < 5; p++) begin
                    if (e_gnt[p]) begin
                        p_first[p] = 1'b0;
                        p_left[p]  = p_left[p] - 1;
                        if (p_left[p] == 0) p_active[p] = 1'b0;
                    end
                end
            end
        end
        RST_ = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_out_arb.md
ROUTER_OUT_ARB -- requirements
Module: router_out_arb

Interface
REQ-001 SHALL have parameter CREDITS, default 4, meaning per-VC downstream buffer depth (range 1..7).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port REQ_VALID  input  5  per input port 0..4: flit present for this output.
REQ-005 SHALL have port REQ_VCH  input  5  per input port: requested output VC (0/1).
REQ-006 SHALL have port REQ_HEAD  input  5  per input port: flit is a head flit.
REQ-007 SHALL have port REQ_TAIL  input  5  per input port: flit is a tail flit (head+tail means single-flit packet).
REQ-008 SHALL have port IACK  input  2  per VC: one credit returned by downstream this cycle.
REQ-009 SHALL have port GNT  output  5  one-hot or zero: input port whose flit is transferred this cycle.
REQ-010 SHALL have port OVALID  output  1  flit transferred this cycle (equals OR of GNT).
REQ-011 SHALL have port OVCH  output  1  VC of transferred flit; 0 when OVALID low.
REQ-012 SHALL have port VC_BUSY  output  2  per VC: VC owned by an input port.
REQ-013 SHALL have port VC_OWNER  output  6  3 bits per VC ([2:0] VC0, [5:3] VC1): owning port index; 0 when free.
REQ-014 SHALL have port CREDIT  output  6  3 bits per VC: current credit count.
REQ-015 SHALL have port ERR  output  1  sticky: credit overflow detected.

Function
REQ-016 SHALL keep per VC a state FREE or OWNED plus a 3-bit owner register.
REQ-017 In FREE, SHALL consider port i a candidate for VC v when REQ_VALID[i], REQ_HEAD[i], REQ_VCH[i]==v.
REQ-018 SHALL pick among candidates by round-robin per VC: search starts at port (last_alloc_v+1) mod 5, wraps 4->0.
REQ-019 On allocation, SHALL set VC v OWNED with owner=winner at the next edge and set last_alloc_v=winner; no flit transferred in the allocation cycle.
REQ-020 Both VCs SHALL be allocatable in the same cycle, including to the same port only if REQ_VCH differs (impossible per port, so distinct ports).
REQ-021 VC v SHALL be link-eligible when OWNED, REQ_VALID[owner], REQ_VCH[owner]==v, and CREDIT_v>0.
REQ-022 GNT/OVALID/OVCH SHALL be combinational from registered state and current inputs; at most one flit per cycle.
REQ-023 If both VCs eligible, SHALL serve the VC not served last (last_vc pointer), then update last_vc to the served VC.
REQ-024 If one VC eligible, SHALL serve it and update last_vc.
REQ-025 Flits with REQ_HEAD set arriving at an already-owned VC from the owner SHALL be transferred as ordinary flits (no re-allocation).
REQ-026 Transfer of a flit with REQ_TAIL set SHALL return that VC to FREE at the next edge; reallocation earliest the following cycle.
REQ-027 Credit per VC SHALL decrement on transfer, increment on IACK, be unchanged when both occur in the same cycle.
REQ-028 IACK while CREDIT==CREDITS and no same-cycle transfer SHALL leave credit at CREDITS and set ERR.
REQ-029 Credit SHALL never go below 0 (guaranteed by REQ-021).
REQ-030 VC_OWNER SHALL read 0 when VC is FREE.

Reset
REQ-031 While RST_ high at an edge: both VCs FREE, owners 0, CREDIT=CREDITS both VCs, last_alloc=4 both VCs (port 0 first), last_vc=1 (VC0 first), ERR=0.
REQ-032 While RST_ high, GNT=0, OVALID=0, OVCH=0 regardless of inputs; reset mid-packet SHALL drop ownership without transfer.

Verification
REQ-033 Port 2 sends head,body,tail on VC0, CREDITS=4 -> alloc cycle 0, GNT=00100 cycles 1..3, CREDIT0 4->1, VC0 FREE at cycle 4.
REQ-034 Ports 0,1,3 all request VC0 single-flit packets repeatedly -> grant order 0,1,3,0 with each alloc/transfer pair.
REQ-035 Port 1 on VC0, port 4 on VC1, both streaming, credits ample -> GNT alternates 00010/10000, OVCH alternates 0/1.
REQ-036 VC0 owned, CREDIT0=0, no IACK -> GNT=0; IACK[0] pulse -> one flit transferred next cycle; simultaneous IACK+transfer -> credit unchanged.
REQ-037 IACK[1] at CREDIT1=4 idle -> CREDIT1 stays 4, ERR=1 and stays 1 until reset.
REQ-038 RST_ asserted mid-packet on VC1 -> next cycle VC_BUSY=00, CREDIT=4/4, GNT=0; new head reallocates normally after release.
